// File: rtl/bus_master.sv
// Queued req/ack bus initiator: buffers client commands, runs one bus transaction
// at a time with a per-transaction timeout, and reports one response per command.
module bus_master #(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        master_1_req,
    output logic [31:0] master_1_addr,
    output logic        master_1_cmd,
    output logic [31:0] master_1_wdata,
    input  logic        master_1_ack,
    input  logic [31:0] master_1_rdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic        rsp_timeout,
    output logic [31:0] rsp_rdata,
    output logic        busy
);
    localparam int unsigned AW = $clog2(CMD_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = 16;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CMD_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, RD_CAP} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic          push, pop;

    logic          fifo_write [CMD_DEPTH];
    logic [31:0]   fifo_addr  [CMD_DEPTH];
    logic [31:0]   fifo_wdata [CMD_DEPTH];

    logic          req_nxt, cmd_nxt;
    logic [31:0]   addr_nxt, wdata_nxt;
    logic          rsp_valid_nxt, rsp_write_nxt, rsp_timeout_nxt;
    logic [31:0]   rsp_rdata_nxt;

    assign push      = cmd_valid && cmd_ready;
    assign count_nxt = count + CW'(push) - CW'(pop);

    // Command storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write[wr_ptr] <= cmd_write;
            fifo_addr[wr_ptr]  <= cmd_addr;
            fifo_wdata[wr_ptr] <= cmd_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            tcnt           <= '0;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            master_1_req   <= 1'b0;
            master_1_addr  <= '0;
            master_1_cmd   <= 1'b0;
            master_1_wdata <= '0;
            rsp_valid      <= 1'b0;
            rsp_write      <= 1'b0;
            rsp_timeout    <= 1'b0;
            rsp_rdata      <= '0;
        end else begin
            state          <= state_nxt;
            count          <= count_nxt;
            tcnt           <= tcnt_nxt;
            cmd_ready      <= (count_nxt != FULL_CNT);
            busy           <= (count_nxt != '0) || (state_nxt != IDLE);
            master_1_req   <= req_nxt;
            master_1_addr  <= addr_nxt;
            master_1_cmd   <= cmd_nxt;
            master_1_wdata <= wdata_nxt;
            rsp_valid      <= rsp_valid_nxt;
            rsp_write      <= rsp_write_nxt;
            rsp_timeout    <= rsp_timeout_nxt;
            rsp_rdata      <= rsp_rdata_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Transaction sequencer; bus fields are zeroed whenever req drops.
    always_comb begin
        state_nxt       = state;
        pop             = 1'b0;
        tcnt_nxt        = tcnt;
        req_nxt         = master_1_req;
        addr_nxt        = master_1_addr;
        cmd_nxt         = master_1_cmd;
        wdata_nxt       = master_1_wdata;
        rsp_valid_nxt   = 1'b0;
        rsp_write_nxt   = rsp_write;
        rsp_timeout_nxt = rsp_timeout;
        rsp_rdata_nxt   = rsp_rdata;

        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    req_nxt   = 1'b1;
                    addr_nxt  = fifo_addr[rd_ptr];
                    cmd_nxt   = fifo_write[rd_ptr];
                    wdata_nxt = fifo_wdata[rd_ptr];
                    tcnt_nxt  = '0;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (master_1_ack) begin
                    if (master_1_cmd) begin
                        req_nxt         = 1'b0;
                        addr_nxt        = '0;
                        cmd_nxt         = 1'b0;
                        wdata_nxt       = '0;
                        rsp_valid_nxt   = 1'b1;
                        rsp_write_nxt   = 1'b1;
                        rsp_timeout_nxt = 1'b0;
                        rsp_rdata_nxt   = '0;
                        state_nxt       = IDLE;
                    end else begin
                        state_nxt = RD_CAP;
                    end
                end else if (tcnt == TO_LAST) begin
                    req_nxt         = 1'b0;
                    addr_nxt        = '0;
                    cmd_nxt         = 1'b0;
                    wdata_nxt       = '0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_write_nxt   = master_1_cmd;
                    rsp_timeout_nxt = 1'b1;
                    rsp_rdata_nxt   = '0;
                    state_nxt       = IDLE;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end
            RD_CAP: begin
                req_nxt         = 1'b0;
                addr_nxt        = '0;
                cmd_nxt         = 1'b0;
                wdata_nxt       = '0;
                rsp_valid_nxt   = 1'b1;
                rsp_write_nxt   = 1'b0;
                rsp_timeout_nxt = 1'b0;
                rsp_rdata_nxt   = master_1_rdata;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bus_master.sv
// Scoreboard bench for bus_master: a slave RAM model with per-transaction ack delay,
// expected responses queued at command accept and compared when rsp_valid pulses.
module tb_bus_master;
    localparam int unsigned CMD_DEPTH      = 4;
    localparam int unsigned TIMEOUT_CYCLES = 8;
    localparam int unsigned NEVER          = 999;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        master_1_req, master_1_cmd, master_1_ack;
    logic [31:0] master_1_addr, master_1_wdata, master_1_rdata;
    logic        rsp_valid, rsp_write, rsp_timeout, busy;
    logic [31:0] rsp_rdata;

    logic        slv_ack = 1'b0;
    logic        spur_ack = 1'b0;
    logic [31:0] slv_rdata = 32'hBAD0_BAD0;

    bus_master #(.CMD_DEPTH(CMD_DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .master_1_req(master_1_req), .master_1_addr(master_1_addr),
        .master_1_cmd(master_1_cmd), .master_1_wdata(master_1_wdata),
        .master_1_ack(master_1_ack), .master_1_rdata(master_1_rdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_timeout(rsp_timeout),
        .rsp_rdata(rsp_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    assign master_1_ack   = slv_ack | spur_ack;
    assign master_1_rdata = slv_rdata;

    typedef struct {
        logic        write;
        logic        timeout;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned req_len;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned delay_q[$];
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] mdl_mem [logic [31:0]];

    int checks = 0;
    int errors = 0;
    int rsp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one command and, on accept, record the response the model predicts.
    task automatic push(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                        input int unsigned delay);
        exp_t e;
        int   n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("push_ready_wait", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.write   = write;
        e.addr    = addr;
        e.wdata   = wdata;
        e.timeout = (delay >= TIMEOUT_CYCLES);
        if (e.timeout) begin
            e.rdata   = '0;
            e.req_len = TIMEOUT_CYCLES;
        end else if (write) begin
            e.rdata      = '0;
            e.req_len    = delay + 1;
            mdl_mem[addr] = wdata;
        end else begin
            e.rdata   = mdl_mem.exists(addr) ? mdl_mem[addr] : 32'h0;
            e.req_len = delay + 2;
        end
        exp_q.push_back(e);
        delay_q.push_back(delay);
    endtask

    task automatic cmd_idle();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rsp_wait", 32'(rsp_cnt), 32'(target));
    endtask

    // Slave: acks in cycle delay+1 of req, returns read data the cycle after ack.
    int unsigned s_cnt, s_delay;
    logic        s_active = 1'b0, s_acked = 1'b0, s_rd_now = 1'b0;
    always @(negedge clk) begin
        slv_ack   = 1'b0;
        slv_rdata = 32'hBAD0_BAD0;
        if (!resetn || !master_1_req) begin
            s_active = 1'b0;
            s_acked  = 1'b0;
            s_rd_now = 1'b0;
        end else begin
            if (!s_active) begin
                s_active = 1'b1;
                s_cnt    = 0;
                s_delay  = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
            end
            s_cnt++;
            if (s_rd_now) begin
                slv_rdata = slv_mem.exists(master_1_addr) ? slv_mem[master_1_addr] : 32'h0;
                s_rd_now  = 1'b0;
            end
            if (!s_acked && s_cnt == s_delay + 1) begin
                slv_ack = 1'b1;
                s_acked = 1'b1;
                if (master_1_cmd) slv_mem[master_1_addr] = master_1_wdata;
                else              s_rd_now = 1'b1;
            end
        end
    end

    // Monitor: bus field checks while req is up/down and scoreboard compare on rsp_valid.
    logic        req_prev = 1'b0;
    int unsigned req_len = 0, last_req_len = 0;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_cmd;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (!resetn) begin
            req_prev = 1'b0;
            req_len  = 0;
        end else begin
            if (master_1_req) begin
                req_len++;
                if (!req_prev) begin
                    if (exp_q.size() == 0) check("req_unexpected", 32'd1, 32'd0);
                    else begin
                        check("req_addr",  master_1_addr,       exp_q[0].addr);
                        check("req_cmd",   32'(master_1_cmd),   32'(exp_q[0].write));
                        check("req_wdata", master_1_wdata,      exp_q[0].wdata);
                    end
                end else begin
                    check("hold_addr",  master_1_addr,     prev_addr);
                    check("hold_cmd",   32'(master_1_cmd), 32'(prev_cmd));
                    check("hold_wdata", master_1_wdata,    prev_wdata);
                end
                prev_addr  = master_1_addr;
                prev_cmd   = master_1_cmd;
                prev_wdata = master_1_wdata;
            end else begin
                if (req_prev) begin
                    last_req_len = req_len;
                    req_len      = 0;
                end
                check("idle_bus", master_1_addr | master_1_wdata | 32'(master_1_cmd), 32'd0);
            end
            req_prev = master_1_req;
            if (rsp_valid) begin
                rsp_cnt++;
                check("rsp_req_low", 32'(master_1_req), 32'd0);
                if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_write",   32'(rsp_write),   32'(mon_e.write));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.timeout));
                    check("rsp_rdata",   rsp_rdata,        mon_e.rdata);
                    check("req_len",     32'(last_req_len), 32'(mon_e.req_len));
                end
            end
        end
    end

    int base;
    initial begin
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_req",       32'(master_1_req), 32'd0);
        check("rst_bus",       master_1_addr | master_1_wdata | 32'(master_1_cmd), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_flags", 32'({rsp_write, rsp_timeout}), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Write with ack two cycles after req rises.
        push(1'b1, 32'h10, 32'hDEAD_BEEF, 2);
        cmd_idle();
        wait_rsp(1);

        // Read back, then mixed traffic queued back-to-back.
        push(1'b0, 32'h10, 32'h0, 0);
        push(1'b1, 32'h14, 32'hCAFE_F00D, 0);
        push(1'b0, 32'h14, 32'h0, 1);
        cmd_idle();
        wait_rsp(4);
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Fill the FIFO behind a slow transaction.
        base = rsp_cnt;
        push(1'b1, 32'h20, 32'hA5A5_A5A5, 6);
        push(1'b1, 32'h100, 32'h1111_1111, 1);
        push(1'b0, 32'h100, 32'h0, 0);
        push(1'b1, 32'h104, 32'h2222_2222, 2);
        push(1'b0, 32'h104, 32'h0, 0);
        #1;
        check("full_ready", 32'(cmd_ready), 32'd0);
        check("full_busy",  32'(busy), 32'd1);
        push(1'b1, 32'h108, 32'h3333_3333, 1);
        check("fifth_after_pop", 32'(rsp_cnt - base), 32'd1);
        cmd_idle();
        wait_rsp(base + 6);

        // Unresponsive slave, then a normal queued read.
        base = rsp_cnt;
        push(1'b1, 32'h200, 32'h4444_4444, NEVER);
        push(1'b0, 32'h104, 32'h0, 0);
        cmd_idle();
        wait_rsp(base + 2);

        // Spurious ack while idle and empty.
        base = rsp_cnt;
        @(negedge clk);
        spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("spur_busy",    32'(busy), 32'd0);
        check("spur_req",     32'(master_1_req), 32'd0);
        check("spur_no_rsp",  32'(rsp_cnt - base), 32'd0);
        push(1'b0, 32'h100, 32'h0, 0);
        cmd_idle();
        wait_rsp(base + 1);

        // Reset while a read sits in RD_CAP with two commands queued.
        base = rsp_cnt;
        push(1'b0, 32'h104, 32'h0, 0);
        push(1'b1, 32'h300, 32'h5555_5555, 0);
        push(1'b0, 32'h104, 32'h0, 0);
        #2;
        cmd_valid = 1'b0;
        check("rdcap_req", 32'(master_1_req), 32'd1);
        resetn = 1'b0;
        #1;
        check("arst_req",       32'(master_1_req), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_busy",      32'(busy), 32'd0);
        exp_q.delete();
        delay_q.delete();
        mdl_mem.delete(32'h300);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_busy",   32'(busy), 32'd0);
        check("post_rst_ready",  32'(cmd_ready), 32'd1);
        check("post_rst_no_rsp", 32'(rsp_cnt - base), 32'd0);

        // Normal operation after reset.
        push(1'b1, 32'h40, 32'h0BAD_F00D, 0);
        push(1'b0, 32'h40, 32'h0, 3);
        cmd_idle();
        wait_rsp(base + 2);
        repeat (3) @(negedge clk);
        check("final_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/bus_master.md
Name: bus_master

Overview:
- Initiator for the crossbar's req/ack memory interface; drives one slave-side port, or one crossbar master port, with queued read/write commands.
- A local command FIFO buffers requests from a test or sequencer client.
- The block sequences the req/ack handshake, captures read data and reports one response per command.
- A per-transaction timeout keeps it from hanging on an unresponsive slave.

Parameters:
- CMD_DEPTH, 4: command FIFO depth in entries; power of two, ≥2.
- TIMEOUT_CYCLES, 64: REQ-state cycles without ack before abort; range 1..65535.

Ports:
- clk  in  1  global clock.
- resetn  in  1  global reset.
- cmd_valid  in  1  client offers a command.
- cmd_ready  out  1  FIFO not full; command accepted when valid&&ready at posedge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  target address.
- cmd_wdata  in  32  write data; ignored for reads.
- master_1_req  out  1  bus request.
- master_1_addr  out  32  bus address.
- master_1_cmd  out  1  1 = write, 0 = read.
- master_1_wdata  out  32  bus write data.
- master_1_ack  in  1  slave acknowledge.
- master_1_rdata  in  32  slave read data.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_write  out  1  echo of command type.
- rsp_timeout  out  1  transaction aborted by timeout.
- rsp_rdata  out  32  read data; 0 for writes and timeouts.
- busy  out  1  FIFO non-empty or state != IDLE.

Behaviour:
- Clock and reset: single clock domain, clk. resetn is asynchronous and active-low.
- Reset values: all outputs 0 except cmd_ready=1; FIFO empty; state IDLE; timeout counter 0.
- Reset mid-transaction: req drops immediately (async); no response is issued; queued commands are lost.
- FIFO push: on cmd_valid&&cmd_ready. cmd_ready = !full, registered-equivalent.
- FIFO pop: only in IDLE. No bypass, so a command pushed into an empty FIFO at edge A gives req=1 after edge A+1.
- Simultaneous push/pop: allowed; count unchanged; pointers wrap modulo CMD_DEPTH.
- All bus outputs are registered. addr, cmd and wdata are loaded at pop and held stable while req=1. They are zeroed when req drops.
- FSM IDLE: if FIFO non-empty → pop, req<=1, counter<=0, go REQ. master_1_ack is ignored in IDLE.
- FSM REQ: sample master_1_ack each posedge.
  - ack=1 and write → req<=0, rsp_valid<=1 (rsp_write=1, rdata=0), go IDLE.
  - ack=1 and read → keep req=1, go RD_CAP. The slave returns rdata the cycle after ack, and only while req is held.
  - ack=0 → counter+1. If counter reaches TIMEOUT_CYCLES-1 → req<=0, rsp_valid<=1, rsp_timeout=1, rdata=0, go IDLE.
- FSM RD_CAP: one cycle. At next posedge capture master_1_rdata into rsp_rdata, req<=0, rsp_valid<=1 (rsp_write=0), go IDLE. master_1_ack is ignored here.
- Spacing: req is low for ≥1 cycle between transactions, since IDLE always costs one cycle. This guarantees the slave clears any stale ack.
- Latency, write with immediate ack: req rises at T, ack seen at T+1, rsp_valid at T+1 output.
- Latency, read: rsp_valid one cycle later than write.
- rsp fields: hold their value until the next response; rsp_valid is high for exactly one cycle per command.
- Timeout counter: 16 bits; saturating not required because it resets per transaction.

Test Plan:
- Write addr 0x10 data 0xDEADBEEF, slave acks 2 cycles after req → req high 3 cycles; addr/wdata/cmd=1 stable throughout; one rsp_valid with rsp_write=1, rsp_rdata=0.
- Read addr 0x10 after that write, against the slave RAM model → req held through the cycle after ack; rsp_rdata=0xDEADBEEF; req low ≥1 cycle before the next transaction.
- Push 5 commands back-to-back with CMD_DEPTH=4 and slave stalled → cmd_ready=0 after the 4th accept. 5th accepted once the first pops. Responses return in order W,R,W,R,W.
- Slave never acks, TIMEOUT_CYCLES=8 → req high exactly 8 cycles; rsp_valid with rsp_timeout=1, rsp_rdata=0; the next queued command then proceeds normally.
- Assert resetn=0 while in RD_CAP with 2 commands queued → req drops asynchronously; no rsp_valid; after release busy=0, cmd_ready=1.
- Spurious ack pulse while in IDLE with FIFO empty → no response, no state change.
